// File: rtl/anu_dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
`timescale 1ns/1ps
package anu_dmem_pkg;

    localparam logic [1:0] MODE_NONE = 2'b00;
    localparam logic [1:0] MODE_BYTE = 2'b01;
    localparam logic [1:0] MODE_HALF = 2'b10;
    localparam logic [1:0] MODE_WORD = 2'b11;

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    // Access captured in IDLE and replayed through WAIT into RESP.
    typedef struct packed {
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [1:0]        mode;
        logic              is_read;
    } req_t;

    // Half and word enables ignore the low address bits, which forces alignment.
    function automatic logic [3:0] byte_en(input logic [1:0] mode, input logic [1:0] lo);
        logic [3:0] be;
        be = 4'b0000;
        case (mode)
            MODE_BYTE: be = 4'b0001 << lo;
            MODE_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
            MODE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core data-port bundle between the core (master) and the data memory (slave).
`timescale 1ns/1ps
interface dmem_responder_if;
    logic [31:0] mem_addr;
    logic [31:0] wdata;
    logic [1:0]  mem_access_mode;
    logic        rd_en;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        stall;
    logic        err;

    modport master (
        output mem_addr, wdata, mem_access_mode, rd_en,
        input  rdata, rdata_valid, stall, err
    );

    modport slave (
        input  mem_addr, wdata, mem_access_mode, rd_en,
        output rdata, rdata_valid, stall, err
    );
endinterface

// File: rtl/dmem_lane_ctrl.sv
// Byte-lane steering: write enables, lane-replicated store data and right-shifted load data.
`timescale 1ns/1ps
module dmem_lane_ctrl
    import anu_dmem_pkg::*;
(
    input  logic [1:0]  mode_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] ram_word_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic [31:0] rword_o
);

    always_comb begin
        be_o    = byte_en(mode_i, addr_lo_i);
        wword_o = wdata_i;
        rword_o = ram_word_i >> {addr_lo_i, 3'b000};
        case (mode_i)
            MODE_BYTE: wword_o = {4{wdata_i[7:0]}};
            MODE_HALF: wword_o = {2{wdata_i[15:0]}};
            default:   wword_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Wait-stated data-memory target for the single-cycle core's data port.
// Optional macro DMEM_ALIGN_CHECK_EN turns misaligned half/word stores and reads into error accesses.
`timescale 1ns/1ps
module dmem_responder
    import anu_dmem_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    dmem_responder_if.slave  bus
);

    localparam int unsigned     AW      = $clog2(DEPTH);
    localparam logic [31:0]     SPAN    = 32'(4 * DEPTH);
    localparam logic [CNT_W-1:0] WS_LOAD = CNT_W'(WAIT_STATES - 1);
    localparam bit              NO_WAIT = (WAIT_STATES == 0);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    req_t              req_q;
    logic [31:0]       rdata_q;
    logic              rdata_valid_q;
    logic              err_q;

    logic [31:0]       mem [DEPTH];

    logic              req_c;
    req_t              live_c;
    req_t              acc_c;
    logic              enter_resp_c;
    logic [31:0]       off_c;
    logic              in_range_c;
    logic              misalign_c;
    logic              bad_c;
    logic [AW-1:0]     idx_c;
    logic [31:0]       ram_word_c;
    logic [3:0]        be_c;
    logic [31:0]       wword_c;
    logic [31:0]       rword_c;
    logic              wr_en_c;

    // A store takes priority over a simultaneous read.
    always_comb begin
        req_c          = bus.rd_en | (bus.mem_access_mode != MODE_NONE);
        live_c.addr    = bus.mem_addr;
        live_c.wdata   = bus.wdata;
        live_c.mode    = bus.mem_access_mode;
        live_c.is_read = (bus.mem_access_mode == MODE_NONE);
    end

    // With no wait states the commit edge comes straight from IDLE, so use the live request there.
    always_comb begin
        acc_c        = (state_q == IDLE) ? live_c : req_q;
        enter_resp_c = ((state_q == IDLE) && req_c && NO_WAIT) ||
                       ((state_q == WAIT) && (cnt_q == '0));
        off_c        = acc_c.addr - BASE_ADDR;
        in_range_c   = (off_c < SPAN);
        idx_c        = off_c[AW+1:2];
`ifdef DMEM_ALIGN_CHECK_EN
        misalign_c   = ((acc_c.mode == MODE_HALF) && acc_c.addr[0]) ||
                       ((acc_c.mode == MODE_WORD) && (acc_c.addr[1:0] != 2'b00)) ||
                       (acc_c.is_read && (acc_c.addr[1:0] != 2'b00));
`else
        misalign_c   = 1'b0;
`endif
        bad_c        = !in_range_c || misalign_c;
        wr_en_c      = enter_resp_c && !acc_c.is_read && !bad_c;
    end

    assign ram_word_c = mem[idx_c];

    dmem_lane_ctrl u_lane_ctrl (
        .mode_i     (acc_c.mode),
        .addr_lo_i  (acc_c.addr[1:0]),
        .wdata_i    (acc_c.wdata),
        .ram_word_i (ram_word_c),
        .be_o       (be_c),
        .wword_o    (wword_c),
        .rword_o    (rword_c)
    );

    // RAM has no reset; a reset in WAIT suppresses the pending commit.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en_c) begin
            for (int b = 0; b < 4; b++) begin
                if (be_c[b]) begin
                    mem[idx_c][8*b +: 8] <= wword_c[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            req_q         <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            rdata_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_c) begin
                        req_q <= live_c;
                        if (NO_WAIT) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= WS_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            // Response data and error are captured on the edge that enters RESP.
            if (enter_resp_c) begin
                if (bad_c) begin
                    err_q   <= 1'b1;
                    rdata_q <= '0;
                end else if (acc_c.is_read) begin
                    rdata_q <= rword_c;
                end
                if (acc_c.is_read) begin
                    rdata_valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.stall       = rst_n && (((state_q == IDLE) && req_c) || (state_q == WAIT));
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (0 and 1 wait states) against a word-array reference model.
`timescale 1ns/1ps
module tb_dmem_responder;
    import anu_dmem_pkg::*;

    localparam int unsigned DEPTH = 64;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dmem_responder_if bus0 ();
    dmem_responder_if bus1 ();

    dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(1), .BASE_ADDR(32'h0)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] ram_m  [2][DEPTH];
    logic        err_m  [2];
    logic [31:0] last_m [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int d, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] mode, input logic rd);
        if (d == 0) begin
            bus0.mem_addr = addr; bus0.wdata = wdata; bus0.mem_access_mode = mode; bus0.rd_en = rd;
        end else begin
            bus1.mem_addr = addr; bus1.wdata = wdata; bus1.mem_access_mode = mode; bus1.rd_en = rd;
        end
    endtask

    function automatic logic get_stall(input int d);
        return (d == 0) ? bus0.stall : bus1.stall;
    endfunction
    function automatic logic get_valid(input int d);
        return (d == 0) ? bus0.rdata_valid : bus1.rdata_valid;
    endfunction
    function automatic logic get_err(input int d);
        return (d == 0) ? bus0.err : bus1.err;
    endfunction
    function automatic logic [31:0] get_rdata(input int d);
        return (d == 0) ? bus0.rdata : bus1.rdata;
    endfunction

    // One complete core access: request held until stall drops, checked in RESP and the following idle cycle.
    task automatic access(input int d, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] mode, input logic rd);
        int          n;
        int          idx;
        int          lo;
        int          b;
        logic        is_rd;
        logic        bad;
        logic [31:0] w;
        n     = 0;
        idx   = int'(addr[31:2]) % DEPTH;
        lo    = int'(addr[1:0]);
        is_rd = (mode == MODE_NONE) && rd;
        bad   = (addr >= 32'(4 * DEPTH));
`ifdef DMEM_ALIGN_CHECK_EN
        if ((mode == MODE_HALF && addr[0]) || (mode == MODE_WORD && lo != 0) || (is_rd && lo != 0))
            bad = 1'b1;
`endif
        if (bad) begin
            err_m[d]  = 1'b1;
            last_m[d] = 32'h0;
        end else if (is_rd) begin
            last_m[d] = ram_m[d][idx] >> (8 * lo);
        end else begin
            w = ram_m[d][idx];
            case (mode)
                MODE_BYTE: w[8*lo +: 8] = wdata[7:0];
                MODE_HALF: begin b = lo & 2; w[8*b +: 16] = wdata[15:0]; end
                default:   w = wdata;
            endcase
            ram_m[d][idx] = w;
        end

        set_req(d, addr, wdata, mode, rd);
        #1;
        while (get_stall(d) && n < 20) begin
            n++;
            @(posedge clk); #1;
        end
        check("stall_cycles", 32'(n), 32'(d + 1));
        check("rvalid_resp", 32'(get_valid(d)), 32'(is_rd));
        check("rdata_resp", get_rdata(d), last_m[d]);
        check("err_resp", 32'(get_err(d)), 32'(err_m[d]));
        set_req(d, 32'h0, 32'h0, MODE_NONE, 1'b0);
        @(posedge clk); #1;
        check("rvalid_idle", 32'(get_valid(d)), 32'h0);
        check("stall_idle", 32'(get_stall(d)), 32'h0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            err_m[d]  = 1'b0;
            last_m[d] = 32'h0;
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  m;
        logic        r;

        rst_n = 1'b0;
        set_req(0, 32'h0, 32'h0, MODE_NONE, 1'b0);
        set_req(1, 32'h10, 32'h0, MODE_NONE, 1'b1);
        @(posedge clk); @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_stall", 32'(get_stall(d)), 32'h0);
            check("rst_rvalid", 32'(get_valid(d)), 32'h0);
            check("rst_rdata", get_rdata(d), 32'h0);
            check("rst_err", 32'(get_err(d)), 32'h0);
            err_m[d]  = 1'b0;
            last_m[d] = 32'h0;
        end
        set_req(1, 32'h0, 32'h0, MODE_NONE, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < int'(DEPTH); i++)
                access(d, 32'(4 * i), 32'h0, MODE_WORD, 1'b0);

        // Word store then read back with one wait state.
        access(1, 32'h10, 32'hDEAD_BEEF, MODE_WORD, 1'b0);
        access(1, 32'h10, 32'h0, MODE_NONE, 1'b1);
        check("tp_word_rd", get_rdata(1), 32'hDEAD_BEEF);

        // Byte store into the top lane, then word and byte reads.
        access(1, 32'h10, 32'h1122_3344, MODE_WORD, 1'b0);
        access(1, 32'h13, 32'h0000_00A5, MODE_BYTE, 1'b0);
        access(1, 32'h10, 32'h0, MODE_NONE, 1'b1);
        check("tp_byte_word", get_rdata(1), 32'hA522_3344);
        access(1, 32'h13, 32'h0, MODE_NONE, 1'b1);
        check("tp_byte_rd", get_rdata(1), 32'h0000_00A5);

        // Zero wait states: upper half store keeps the lower half.
        access(0, 32'h20, 32'h1234_5678, MODE_WORD, 1'b0);
        access(0, 32'h22, 32'h0000_CAFE, MODE_HALF, 1'b0);
        access(0, 32'h20, 32'h0, MODE_NONE, 1'b1);
        check("tp_half_rd", get_rdata(0), 32'hCAFE_5678);

        // Store and read together: store wins, no read valid.
        access(1, 32'h30, 32'h5555_5555, MODE_WORD, 1'b1);
        access(1, 32'h30, 32'h0, MODE_NONE, 1'b1);
        check("tp_store_wins", get_rdata(1), 32'h5555_5555);

        // Out-of-range store: sticky error, no aliasing write, cleared by reset.
        access(1, 32'(4 * DEPTH), 32'hFFFF_FFFF, MODE_WORD, 1'b0);
        check("tp_oor_err", 32'(get_err(1)), 32'h1);
        access(1, 32'h0, 32'h0, MODE_NONE, 1'b1);
        access(1, 32'h10, 32'h0, MODE_NONE, 1'b1);
        check("tp_oor_sticky", 32'(get_err(1)), 32'h1);
        pulse_reset();
        check("tp_oor_cleared", 32'(get_err(1)), 32'h0);

        // Reset in the middle of WAIT aborts the store.
        set_req(1, 32'h40, 32'h1234_5678, MODE_WORD, 1'b0);
        @(posedge clk); #1;
        check("tp_in_wait", 32'(get_stall(1)), 32'h1);
        rst_n = 1'b0;
        set_req(1, 32'h0, 32'h0, MODE_NONE, 1'b0);
        @(posedge clk); #1;
        check("tp_abort_stall", 32'(get_stall(1)), 32'h0);
        rst_n = 1'b1;
        last_m[0] = 32'h0; last_m[1] = 32'h0;
        err_m[0]  = 1'b0;  err_m[1]  = 1'b0;
        @(posedge clk); #1;
        access(1, 32'h40, 32'h0, MODE_NONE, 1'b1);
        check("tp_abort_nowrite", get_rdata(1), 32'h0);

`ifdef DMEM_ALIGN_CHECK_EN
        access(1, 32'h41, 32'hFFFF_FFFF, MODE_WORD, 1'b0);
        check("tp_align_err", 32'(get_err(1)), 32'h1);
        access(1, 32'h40, 32'h0, MODE_NONE, 1'b1);
        check("tp_align_nowrite", get_rdata(1), 32'h0);
`endif

        // Random mix of sizes, offsets and occasional out-of-range addresses.
        for (int k = 0; k < 120; k++) begin
            a = 32'($urandom_range(0, 4 * DEPTH + 15));
            m = 2'($urandom_range(0, 3));
            r = 1'($urandom_range(0, 1));
            if (m == MODE_NONE) r = 1'b1;
            access(k % 2, a, $urandom, m, r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
